// File: rtl/fetch_stage.sv
// Multi-cycle instruction fetch stage: owns the PC, issues one memory request at a time,
// hands fetched words to decode over valid/ready and honours redirects from execute.
module fetch_stage #(
    parameter int unsigned       XLEN     = 32,
    parameter logic [XLEN-1:0]   RESET_PC = 32'h8000_0000
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    output logic            imem_req_valid_o,
    input  logic            imem_req_ready_i,
    output logic [XLEN-1:0] imem_req_addr_o,
    input  logic            imem_rsp_valid_i,
    input  logic [31:0]     imem_rsp_data_i,
    output logic            inst_valid_o,
    input  logic            inst_ready_i,
    output logic [31:0]     inst_o,
    output logic [XLEN-1:0] pc_o,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic              drop_q, drop_d;
    logic [31:0]       inst_q, inst_d;
    logic [XLEN-1:0]   pc_out_q, pc_out_d;
    logic              inc_s;
    logic [XLEN-1:0]   redirect_tgt_s;

    assign redirect_tgt_s   = {redirect_pc_i[XLEN-1:2], 2'b00};
    assign imem_req_valid_o = (state_q == REQ);
    assign imem_req_addr_o  = pc_q;
    assign inst_valid_o     = (state_q == HOLD);
    assign inst_o           = inst_q;
    assign pc_o             = pc_out_q;

    // Next-state, drop flag, captured instruction and PC update.
    always_comb begin
        state_d  = state_q;
        drop_d   = drop_q;
        inst_d   = inst_q;
        pc_out_d = pc_out_q;
        inc_s    = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = REQ;
            end
            REQ: begin
                if (imem_req_ready_i) begin
                    // the accepted request already carries the old address
                    state_d = WAIT;
                    drop_d  = redirect_valid_i;
                end else begin
                    state_d = REQ;
                end
            end
            WAIT: begin
                if (imem_rsp_valid_i) begin
                    drop_d = 1'b0;
                    if (!drop_q && !redirect_valid_i) begin
                        inst_d   = imem_rsp_data_i;
                        pc_out_d = pc_q;
                        state_d  = HOLD;
                    end else begin
                        state_d = REQ;
                    end
                end else if (redirect_valid_i) begin
                    drop_d = 1'b1;
                end else begin
                    drop_d = drop_q;
                end
            end
            HOLD: begin
                if (redirect_valid_i) begin
                    state_d = REQ;
                end else if (inst_ready_i) begin
                    state_d = REQ;
                    inc_s   = 1'b1;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = IDLE;
                drop_d  = 1'b0;
            end
        endcase

        if (redirect_valid_i) begin
            pc_d = redirect_tgt_s;
        end else if (inc_s) begin
            pc_d = pc_q + XLEN'(3'd4);
        end else begin
            pc_d = pc_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            drop_q   <= 1'b0;
            inst_q   <= 32'h0000_0000;
            pc_out_q <= RESET_PC;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            drop_q   <= drop_d;
            inst_q   <= inst_d;
            pc_out_q <= pc_out_d;
        end
    end

    fetch_stage_chk u_chk (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .in_wait_i     (state_q == WAIT),
        .req_valid_i   (imem_req_valid_o),
        .inst_valid_i  (inst_valid_o),
        .rsp_valid_i   (imem_rsp_valid_i)
    );

endmodule

// Protocol checker: responses only while waiting, never request and instruction valid together.
module fetch_stage_chk (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic in_wait_i,
    input  logic req_valid_i,
    input  logic inst_valid_i,
    input  logic rsp_valid_i
);

    a_rsp_in_wait: assert property (@(posedge clk_i) disable iff (!rst_ni)
        rsp_valid_i |-> in_wait_i);

    a_valid_exclusive: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(req_valid_i && inst_valid_i));

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: memory and decode are driven by hand, one step per clock.
module tb_fetch_stage;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i;
    logic [31:0] imem_req_addr_o;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;

    int checks = 0;
    int errors = 0;

    fetch_stage #(.XLEN(32), .RESET_PC(32'h8000_0000)) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_req_addr_o  (imem_req_addr_o),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .inst_valid_o     (inst_valid_o),
        .inst_ready_i     (inst_ready_i),
        .inst_o           (inst_o),
        .pc_o             (pc_o),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " req_valid"},  {31'd0, imem_req_valid_o}, 32'd0);
        check({tag, " inst_valid"}, {31'd0, inst_valid_o},     32'd0);
        check({tag, " inst"},       inst_o,                    32'h0000_0000);
        check({tag, " pc"},         pc_o,                      32'h8000_0000);
    endtask

    initial begin
        rst_ni           = 1'b0;
        imem_req_ready_i = 1'b1;
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = 32'h0;
        inst_ready_i     = 1'b1;
        redirect_valid_i = 1'b0;
        redirect_pc_i    = 32'h0;

        // 1: reset values, first fetch, hand-off to decode
        tick();
        tick();
        check_reset_outputs("reset");
        rst_ni = 1'b1;
        tick();
        check("t1 req_valid", {31'd0, imem_req_valid_o}, 32'd1);
        check("t1 req_addr", imem_req_addr_o, 32'h8000_0000);
        tick();
        check("t1 wait req_valid", {31'd0, imem_req_valid_o}, 32'd0);
        check("t1 wait inst_valid", {31'd0, inst_valid_o}, 32'd0);
        imem_rsp_valid_i = 1'b1;
        imem_rsp_data_i  = 32'h0000_0413;
        tick();
        imem_rsp_valid_i = 1'b0;
        check("t1 inst_valid", {31'd0, inst_valid_o}, 32'd1);
        check("t1 inst", inst_o, 32'h0000_0413);
        check("t1 pc", pc_o, 32'h8000_0000);
        check("t1 hold no req", {31'd0, imem_req_valid_o}, 32'd0);
        tick();
        check("t1 next req_valid", {31'd0, imem_req_valid_o}, 32'd1);
        check("t1 next addr", imem_req_addr_o, 32'h8000_0004);
        check("t1 next inst_valid", {31'd0, inst_valid_o}, 32'd0);

        // 2: decode backpressure for 5 cycles
        inst_ready_i = 1'b0;
        tick();
        imem_rsp_valid_i = 1'b1;
        imem_rsp_data_i  = 32'h0010_0093;
        tick();
        imem_rsp_valid_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("t2 inst_valid", {31'd0, inst_valid_o}, 32'd1);
            check("t2 inst", inst_o, 32'h0010_0093);
            check("t2 pc", pc_o, 32'h8000_0004);
            check("t2 no req", {31'd0, imem_req_valid_o}, 32'd0);
            tick();
        end
        inst_ready_i = 1'b1;
        tick();
        check("t2 req_valid", {31'd0, imem_req_valid_o}, 32'd1);
        check("t2 addr", imem_req_addr_o, 32'h8000_0008);

        // 4: redirect together with a request handshake at 0x80000008
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 32'h8000_0200;
        tick();
        redirect_valid_i = 1'b0;
        check("t4 wait req_valid", {31'd0, imem_req_valid_o}, 32'd0);
        imem_rsp_valid_i = 1'b1;
        imem_rsp_data_i  = 32'hDEAD_BEEF;
        tick();
        imem_rsp_valid_i = 1'b0;
        check("t4 dropped inst_valid", {31'd0, inst_valid_o}, 32'd0);
        check("t4 req_valid", {31'd0, imem_req_valid_o}, 32'd1);
        check("t4 addr", imem_req_addr_o, 32'h8000_0200);

        // 3: redirect to an unaligned target while waiting for a response
        tick();
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 32'h8000_0102;
        tick();
        redirect_valid_i = 1'b0;
        check("t3 still wait", {31'd0, imem_req_valid_o}, 32'd0);
        imem_rsp_valid_i = 1'b1;
        imem_rsp_data_i  = 32'hCAFE_F00D;
        tick();
        imem_rsp_valid_i = 1'b0;
        check("t3 dropped inst_valid", {31'd0, inst_valid_o}, 32'd0);
        check("t3 req_valid", {31'd0, imem_req_valid_o}, 32'd1);
        check("t3 addr", imem_req_addr_o, 32'h8000_0100);

        // redirect of a request the memory has not accepted yet
        imem_req_ready_i = 1'b0;
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 32'h8000_0300;
        tick();
        redirect_valid_i = 1'b0;
        imem_req_ready_i = 1'b1;
        check("t3b req_valid", {31'd0, imem_req_valid_o}, 32'd1);
        check("t3b addr", imem_req_addr_o, 32'h8000_0300);

        // 5: redirect and decode handshake in the same HOLD cycle
        tick();
        imem_rsp_valid_i = 1'b1;
        imem_rsp_data_i  = 32'h0050_0113;
        tick();
        imem_rsp_valid_i = 1'b0;
        check("t5 inst_valid", {31'd0, inst_valid_o}, 32'd1);
        check("t5 pc", pc_o, 32'h8000_0300);
        check("t5 inst", inst_o, 32'h0050_0113);
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 32'h8000_0400;
        tick();
        redirect_valid_i = 1'b0;
        check("t5 squashed", {31'd0, inst_valid_o}, 32'd0);
        check("t5 req_valid", {31'd0, imem_req_valid_o}, 32'd1);
        check("t5 addr", imem_req_addr_o, 32'h8000_0400);

        // 6: reset in WAIT, stray response, restart, then PC wrap
        tick();
        rst_ni = 1'b0;
        #1;
        check_reset_outputs("t6 reset");
        check("t6 reset addr", imem_req_addr_o, 32'h8000_0000);
        imem_rsp_valid_i = 1'b1;
        imem_rsp_data_i  = 32'h1234_5678;
        tick();
        imem_rsp_valid_i = 1'b0;
        rst_ni = 1'b1;
        check_reset_outputs("t6 after stray");
        tick();
        check("t6 restart req_valid", {31'd0, imem_req_valid_o}, 32'd1);
        check("t6 restart addr", imem_req_addr_o, 32'h8000_0000);
        check("t6 restart inst_valid", {31'd0, inst_valid_o}, 32'd0);

        imem_req_ready_i = 1'b0;
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 32'hFFFF_FFFC;
        tick();
        redirect_valid_i = 1'b0;
        imem_req_ready_i = 1'b1;
        check("t6 wrap addr", imem_req_addr_o, 32'hFFFF_FFFC);
        tick();
        imem_rsp_valid_i = 1'b1;
        imem_rsp_data_i  = 32'h0000_0013;
        tick();
        imem_rsp_valid_i = 1'b0;
        check("t6 wrap pc", pc_o, 32'hFFFF_FFFC);
        check("t6 wrap inst", inst_o, 32'h0000_0013);
        tick();
        check("t6 wrap req_valid", {31'd0, imem_req_valid_o}, 32'd1);
        check("t6 wrapped addr", imem_req_addr_o, 32'h0000_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
